// File: rtl/ram_arbiter.sv
// Two-requester arbiter sharing one single-port RAM between instruction fetch and data ports.
// Optional macro RAM_ARB_RR_EN selects round-robin arbitration instead of fixed data-first priority.

package ram_arbiter_pkg;
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;
endpackage

module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int unsigned ERR_LIMIT = 15
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic [31:0] iload,
    output logic        iwait,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic [31:0] dload,
    output logic        dwait,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  ramstate_t   ramstate,
    output logic        arb_err
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISERVE = 2'd1,
        DSERVE = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_err_cnt;
`ifdef RAM_ARB_RR_EN
    logic             r_last_d;
`endif

    logic             w_dreq;
    logic             w_gnt_req;
    logic             w_done;
    logic             w_drop;
    logic             w_err_hit;
    logic [CNT_W-1:0] w_err_inc;
    state_t           w_pick;

    // Grant bookkeeping: live request of the granted port, completion, withdrawal, error limit
    always_comb begin
        w_dreq    = dREN | dWEN;
        w_gnt_req = 1'b0;
        case (r_state)
            ISERVE:  w_gnt_req = iREN;
            DSERVE:  w_gnt_req = w_dreq;
            default: w_gnt_req = 1'b0;
        endcase
        w_done    = (r_state != IDLE) && w_gnt_req && (ramstate == ACCESS);
        w_drop    = (r_state != IDLE) && !w_gnt_req;
        w_err_inc = r_err_cnt + CNT_W'(1);
        w_err_hit = (r_state != IDLE) && w_gnt_req && (ramstate == ERROR)
                    && (w_err_inc == CNT_W'(ERR_LIMIT));
    end

    // Winner selection when leaving IDLE
    always_comb begin
`ifdef RAM_ARB_RR_EN
        if (w_dreq && iREN) begin
            w_pick = r_last_d ? ISERVE : DSERVE;
        end else begin
            w_pick = w_dreq ? DSERVE : ISERVE;
        end
`else
        w_pick = w_dreq ? DSERVE : ISERVE;
`endif
    end

    // RAM request forwarding and port handshake; waits mirror requests except on completion
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = 32'd0;
        ramstore = 32'd0;
        iwait    = iREN;
        dwait    = w_dreq;
        iload    = 32'd0;
        dload    = 32'd0;
        case (r_state)
            ISERVE: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                if (w_done) begin
                    iwait = 1'b0;
                    iload = ramload;
                end
            end
            DSERVE: begin
                ramREN   = dREN;
                ramWEN   = dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                if (w_done) begin
                    dwait = 1'b0;
                    dload = ramload;
                end
            end
            default: begin
                ramREN = 1'b0;
            end
        endcase
    end

    // Grant FSM; every grant returns through IDLE so RAM enables drop between transactions
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state   <= IDLE;
            r_err_cnt <= '0;
            arb_err   <= 1'b0;
`ifdef RAM_ARB_RR_EN
            r_last_d  <= 1'b0;
`endif
        end else begin
            arb_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_err_cnt <= '0;
                    if (iREN || w_dreq) begin
                        r_state <= w_pick;
                    end
                end
                default: begin
                    if (w_drop || w_done) begin
                        r_state   <= IDLE;
                        r_err_cnt <= '0;
`ifdef RAM_ARB_RR_EN
                        if (w_done) begin
                            r_last_d <= (r_state == DSERVE);
                        end
`endif
                    end else if (ramstate == ERROR) begin
                        if (w_err_hit) begin
                            r_state   <= IDLE;
                            r_err_cnt <= '0;
                            arb_err   <= 1'b1;
                        end else begin
                            r_err_cnt <= w_err_inc;
                        end
                    end else begin
                        r_err_cnt <= '0;
                    end
                end
            endcase
        end
    end

endmodule
